// File: rtl/issue_scheduler.sv
// issue_scheduler: issue-stage gate in front of the single-cycle ALU and the
// unpipelined multi-cycle MUL unit. Holds a busy scoreboard for RAW/WAW
// hazards and reserves the shared register-file write port per cycle.
// Ports:
//   clk, rst (async, active-high), flush (sync kill of in-flight state)
//   id_*        decoded instruction in; id_ready is the combinational accept
//   wb_valid/wb_rd/wb_sel_mul  registered regfile write port control
//   mul_busy    MUL unit occupied; stall_cnt saturating count of stall cycles
// Optional feature: define ISSUE_BYPASS_EN to let a source whose writeback is
// in the current cycle count as ready (the datapath forwards the result).

module issue_scheduler #(
  parameter int ALU_LAT = 1,
  parameter int MUL_LAT = 4,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             id_valid,
  output logic             id_ready,
  input  logic [4:0]       id_rd,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic             id_wr_en,
  input  logic             id_is_mul,
  output logic             wb_valid,
  output logic [4:0]       wb_rd,
  output logic             wb_sel_mul,
  output logic             mul_busy,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int MC_W = $clog2(MUL_LAT + 1);

  typedef struct packed {
    logic       vld;
    logic [4:0] rd;
    logic       sel_mul;
  } slot_t;

  // slot_q[0] is the registered writeback stage itself; slot_q[k] reaches
  // the writeback stage after k more edges. An op of latency L is written
  // into position L-1 at its issue edge.
  slot_t [MUL_LAT-1:0] slot_q, slot_d;
  logic  [31:0]        busy_q, busy_d;
  logic  [MC_W-1:0]    mul_cnt_q, mul_cnt_d;
  logic  [CNT_W-1:0]   stall_q, stall_d;

  logic        writes;
  logic        raw1, raw2, waw, port_hit, struct_hit;
  logic        issue;
  logic [31:0] fwd;
  logic [31:0] busy_eff;
  int          lat;

  assign wb_valid   = slot_q[0].vld;
  assign wb_rd      = slot_q[0].rd;
  assign wb_sel_mul = slot_q[0].sel_mul;
  assign mul_busy   = (mul_cnt_q != '0);
  assign stall_cnt  = stall_q;

  // Registers retiring in the current cycle; only they may be forwarded.
  always_comb begin
    fwd = '0;
`ifdef ISSUE_BYPASS_EN
    if (slot_q[0].vld) fwd[slot_q[0].rd] = 1'b1;
`endif
  end

  assign busy_eff = busy_q & ~fwd;

  always_comb begin
    lat        = id_is_mul ? MUL_LAT : ALU_LAT;
    writes     = id_wr_en && (id_rd != 5'd0);
    raw1       = id_use_rs1 && (id_rs1 != 5'd0) && busy_eff[id_rs1];
    raw2       = id_use_rs2 && (id_rs2 != 5'd0) && busy_eff[id_rs2];
    waw        = writes && busy_eff[id_rd];
    struct_hit = id_is_mul && mul_busy;
    // The entry that would shift into our landing position is slot_q[lat];
    // a latency equal to MUL_LAT lands in the tail, which is always free.
    port_hit   = 1'b0;
    for (int k = 1; k < MUL_LAT; k++) begin
      if (writes && (k == lat)) port_hit = slot_q[k].vld;
    end
    id_ready = !rst && !flush && !(raw1 || raw2 || waw || struct_hit || port_hit);
  end

  assign issue = id_valid && id_ready;

  always_comb begin
    for (int k = 0; k < MUL_LAT - 1; k++) slot_d[k] = slot_q[k+1];
    slot_d[MUL_LAT-1] = '0;

    busy_d = busy_q;
    if (slot_q[0].vld) busy_d[slot_q[0].rd] = 1'b0;

    mul_cnt_d = (mul_cnt_q != '0) ? mul_cnt_q - MC_W'(1) : mul_cnt_q;

    // Set after clear so a same-edge set on a retiring register wins.
    if (issue) begin
      if (writes) begin
        busy_d[id_rd] = 1'b1;
        for (int k = 0; k < MUL_LAT; k++) begin
          if (k == lat - 1) slot_d[k] = slot_t'{vld: 1'b1, rd: id_rd, sel_mul: id_is_mul};
        end
      end
      // Counts the cycles before the MUL writeback cycle, so the next MUL
      // may issue during that writeback cycle.
      if (id_is_mul) mul_cnt_d = MC_W'(MUL_LAT - 1);
    end

    if (flush) begin
      slot_d    = '0;
      busy_d    = '0;
      mul_cnt_d = '0;
    end
    busy_d[0] = 1'b0;

    stall_d = stall_q;
    if (id_valid && !id_ready && (stall_q != {CNT_W{1'b1}})) stall_d = stall_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_q    <= '0;
      busy_q    <= '0;
      mul_cnt_q <= '0;
      stall_q   <= '0;
    end else begin
      slot_q    <= slot_d;
      busy_q    <= busy_d;
      mul_cnt_q <= mul_cnt_d;
      stall_q   <= stall_d;
    end
  end

endmodule

// File: tb/tb_issue_scheduler.sv
// tb_issue_scheduler: directed vectors for issue_scheduler with hand-computed
// expectations. Runs the DUT with MUL_LAT=4 and a 4-bit stall counter so the
// saturation point is reachable in a few cycles.
// Inputs change 1 time unit after the rising edge; outputs are read 2 units later.

module tb_issue_scheduler;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush = 1'b0;
  logic          id_valid = 1'b0;
  logic          id_ready;
  logic [4:0]    id_rd = '0, id_rs1 = '0, id_rs2 = '0;
  logic          id_use_rs1 = 1'b0, id_use_rs2 = 1'b0, id_wr_en = 1'b0, id_is_mul = 1'b0;
  logic          wb_valid;
  logic [4:0]    wb_rd;
  logic          wb_sel_mul;
  logic          mul_busy;
  logic [CW-1:0] stall_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_stall = 0;
  int waited, busy_seen;
  logic byp;

  issue_scheduler #(.ALU_LAT(1), .MUL_LAT(4), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .id_valid(id_valid), .id_ready(id_ready),
    .id_rd(id_rd), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_wr_en(id_wr_en), .id_is_mul(id_is_mul),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_sel_mul(wb_sel_mul),
    .mul_busy(mul_busy), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic drive(input logic v, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic u1, input logic u2,
                       input logic wr, input logic mul);
    id_valid = v; id_rd = rd; id_rs1 = rs1; id_rs2 = rs2;
    id_use_rs1 = u1; id_use_rs2 = u2; id_wr_en = wr; id_is_mul = mul;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
`ifdef ISSUE_BYPASS_EN
    byp = 1'b1;
`else
    byp = 1'b0;
`endif
    // ---- reset state: id_ready held low, everything cleared
    drive(1'b1, 5'd1, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0);
    #2;
    check_eq("rst_ready", 32'(id_ready), 32'd0);
    check_eq("rst_wb_valid", 32'(wb_valid), 32'd0);
    check_eq("rst_wb_rd", 32'(wb_rd), 32'd0);
    check_eq("rst_wb_sel", 32'(wb_sel_mul), 32'd0);
    check_eq("rst_mul_busy", 32'(mul_busy), 32'd0);
    check_eq("rst_stall", 32'(stall_cnt), 32'd0);
    idle();
    tick(); tick();
    rst = 1'b0;

    // ---- ADDI x1 ; ADDI x2 back to back
    drive(1'b1, 5'd1, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0);
    settle(); check_eq("addi1_ready", 32'(id_ready), 32'd1);
    tick();
    drive(1'b1, 5'd2, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0);
    settle();
    check_eq("addi2_ready", 32'(id_ready), 32'd1);
    check_eq("addi1_wb_valid", 32'(wb_valid), 32'd1);
    check_eq("addi1_wb_rd", 32'(wb_rd), 32'd1);
    check_eq("addi1_wb_sel", 32'(wb_sel_mul), 32'd0);
    tick();
    idle(); settle();
    check_eq("addi2_wb_valid", 32'(wb_valid), 32'd1);
    check_eq("addi2_wb_rd", 32'(wb_rd), 32'd2);
    tick(); settle();
    check_eq("addi_drain_wb", 32'(wb_valid), 32'd0);
    check_eq("addi_stall", 32'(stall_cnt), 32'd0);

    // ---- ADDI x1 ; ADD x3,x1,x2 (RAW)
    tick();
    drive(1'b1, 5'd1, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    drive(1'b1, 5'd3, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0);
    settle();
    check_eq("raw_first_ready", 32'(id_ready), byp ? 32'd1 : 32'd0);
    if (!byp) begin
      exp_stall++;
      tick(); settle();
      check_eq("raw_second_ready", 32'(id_ready), 32'd1);
    end
    tick();
    idle(); settle();
    check_eq("raw_wb_rd", 32'(wb_rd), 32'd3);
    check_eq("raw_stall", 32'(stall_cnt), 32'(exp_stall));
    tick(); tick();

    // ---- MUL x5,x1,x2 then ALU write x7 at +3 (port conflict)
    drive(1'b1, 5'd5, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b1);
    settle(); check_eq("mul5_ready", 32'(id_ready), 32'd1);
    tick();
    idle(); settle();
    check_eq("mul5_busy_c1", 32'(mul_busy), 32'd1);
    tick(); tick();
    drive(1'b1, 5'd7, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    settle();
    check_eq("port_conflict_ready", 32'(id_ready), 32'd0);
    check_eq("mul5_busy_c3", 32'(mul_busy), 32'd1);
    exp_stall++;
    tick(); settle();
    check_eq("mul5_wb_valid", 32'(wb_valid), 32'd1);
    check_eq("mul5_wb_rd", 32'(wb_rd), 32'd5);
    check_eq("mul5_wb_sel", 32'(wb_sel_mul), 32'd1);
    check_eq("mul5_busy_wb", 32'(mul_busy), 32'd0);
    check_eq("alu7_ready", 32'(id_ready), 32'd1);
    tick();
    idle(); settle();
    check_eq("alu7_wb_rd", 32'(wb_rd), 32'd7);
    check_eq("alu7_wb_sel", 32'(wb_sel_mul), 32'd0);
    check_eq("port_stall", 32'(stall_cnt), 32'(exp_stall));
    tick(); tick();

    // ---- two independent MULs back to back
    drive(1'b1, 5'd6, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    drive(1'b1, 5'd8, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    waited = 0; busy_seen = 0;
    for (int i = 0; i < 10; i++) begin
      settle();
      if (id_ready) break;
      waited++;
      if (mul_busy) busy_seen++;
      tick();
    end
    check_eq("mul_spacing_wait", 32'(waited), 32'd3);
    check_eq("mul_busy_cycles", 32'(busy_seen), 32'd3);
    exp_stall += 3;
    tick();
    idle();
    for (int i = 0; i < 5; i++) tick();
    settle();
    check_eq("mulmul_stall", 32'(stall_cnt), 32'(exp_stall));

    // ---- ADDI x0,x0,1: issues, no writeback, no busy
    drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0);
    settle(); check_eq("x0_ready", 32'(id_ready), 32'd1);
    tick();
    drive(1'b1, 5'd4, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0);
    settle();
    check_eq("x0_wb_valid", 32'(wb_valid), 32'd0);
    check_eq("x0_reader_ready", 32'(id_ready), 32'd1);
    tick();
    idle(); tick(); tick();

    // ---- MUL then flush two cycles later
    drive(1'b1, 5'd9, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    idle(); tick();
    flush = 1'b1;
    drive(1'b1, 5'd10, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    settle();
    check_eq("flush_ready", 32'(id_ready), 32'd0);
    exp_stall++;
    tick();
    flush = 1'b0;
    drive(1'b1, 5'd9, 5'd9, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1);
    settle();
    check_eq("post_flush_ready", 32'(id_ready), 32'd1);
    check_eq("post_flush_mul_busy", 32'(mul_busy), 32'd0);
    check_eq("post_flush_wb0", 32'(wb_valid), 32'd0);
    check_eq("flush_stall_kept", 32'(stall_cnt), 32'(exp_stall));
    tick();
    idle(); settle();
    check_eq("post_flush_wb1", 32'(wb_valid), 32'd0);
    tick(); tick(); settle();
    check_eq("post_flush_wb3", 32'(wb_valid), 32'd0);
    tick(); settle();
    check_eq("refill_wb_valid", 32'(wb_valid), 32'd1);
    check_eq("refill_wb_rd", 32'(wb_rd), 32'd9);
    tick();

    // ---- stall counter saturation (held-off request under flush)
    flush = 1'b1;
    drive(1'b1, 5'd1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) tick();
    settle();
    check_eq("stall_saturate", 32'(stall_cnt), 32'd15);
    flush = 1'b0;
    idle(); tick();

    // ---- MUL then reset two cycles later
    drive(1'b1, 5'd11, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    idle(); tick();
    rst = 1'b1;
    drive(1'b1, 5'd12, 5'd11, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1);
    settle();
    check_eq("rst_mid_ready", 32'(id_ready), 32'd0);
    check_eq("rst_mid_mul_busy", 32'(mul_busy), 32'd0);
    check_eq("rst_mid_stall", 32'(stall_cnt), 32'd0);
    tick();
    rst = 1'b0;
    settle();
    check_eq("post_rst_ready", 32'(id_ready), 32'd1);
    tick();
    idle(); settle();
    check_eq("post_rst_wb1", 32'(wb_valid), 32'd0);
    tick(); settle();
    check_eq("post_rst_wb2", 32'(wb_valid), 32'd0);
    tick(); settle();
    check_eq("post_rst_wb3", 32'(wb_valid), 32'd0);
    tick(); settle();
    check_eq("post_rst_mul_wb", 32'(wb_valid), 32'd1);
    check_eq("post_rst_mul_rd", 32'(wb_rd), 32'd12);
    check_eq("post_rst_stall", 32'(stall_cnt), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation did not complete, limit 50000");
    $fatal(1);
  end

endmodule
